ex_stage_md: RTL and testbench

EX_STAGE_MD -- requirements
Module: ex_stage_md

---
 rtl/ex_stage_md.sv | 199 +++++++++++++++++++
 tb/tb_ex_stage_md.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding muxes, RV32I-style ALU, iterative multiply/divide FSM.
// Optional divider built only when EX_STAGE_MD_DIV_EN is defined.
module ex_stage_md #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [1:0]      alu_op,
    input  logic            alu_src,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] mem_data,
    input  logic            flush,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] store_data,
    output logic            valid_out,
    output logic            stall_out
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;

    logic [XLEN-1:0] op_a, op_b_fwd, op_b, base_res, sra_res;
    logic [CW-1:0]   shamt, cnt;
    logic [XLEN-1:0] hi, lo, mcand, m_result;
    logic [2:0]      f3;
    logic            neg_q, m_op, m_iter, accept, last;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi, mul_lo, mul_res;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        unique case (fwd_a)
            2'b01:   op_a = wb_data;
            2'b10:   op_a = mem_data;
            2'b11:   op_a = '0;
            default: op_a = rs1_data;
        endcase
        unique case (fwd_b)
            2'b01:   op_b_fwd = wb_data;
            2'b10:   op_b_fwd = mem_data;
            2'b11:   op_b_fwd = '0;
            default: op_b_fwd = rs2_data;
        endcase
        op_b = alu_src ? imm : op_b_fwd;
    end

    assign store_data    = op_b_fwd;
    assign branch_target = pc + imm;
    assign shamt         = op_b[CW-1:0];
    // Kept apart from the case below so the mixed-sign mux cannot demote it to a logical shift.
    assign sra_res       = $signed(op_a) >>> shamt;

    always_comb begin
        base_res = '0;
        unique case (alu_op)
            2'b00: base_res = op_a + op_b;
            2'b01: base_res = op_a - op_b;
            default: begin
                unique case (funct3)
                    3'b000:  base_res = (alu_op == 2'b10 && funct7[5]) ? op_a - op_b : op_a + op_b;
                    3'b001:  base_res = op_a << shamt;
                    3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    3'b011:  base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
                    3'b100:  base_res = op_a ^ op_b;
                    3'b101:  base_res = funct7[5] ? sra_res : op_a >> shamt;
                    3'b110:  base_res = op_a | op_b;
                    default: base_res = op_a & op_b;
                endcase
            end
        endcase
    end

    assign m_op = (alu_op == 2'b10) && (funct7 == 7'b0000001);
`ifdef EX_STAGE_MD_DIV_EN
    assign m_iter = m_op;
`else
    assign m_iter = m_op && !funct3[2];
`endif
    assign accept = (state == IDLE) && valid_in && !flush && m_iter;
    assign last   = (cnt == CW'(XLEN - 1));

    // Both units work on magnitudes; signs are re-applied when the result is captured.
    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        abs_a    = a_neg ? -op_a : op_a;
        abs_b    = b_neg ? -op_b : op_b;
        mul_sum  = {1'b0, hi} + {1'b0, mcand & {XLEN{lo[0]}}};
        mul_hi   = mul_sum[XLEN:1];
        mul_lo   = {mul_sum[0], lo[XLEN-1:1]};
        prod     = {mul_hi, mul_lo};
        prod_s   = neg_q ? -prod : prod;
        mul_res  = (f3 == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

`ifdef EX_STAGE_MD_DIV_EN
    logic            neg_r, dz;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] nrem, nquo, div_res;

    always_comb begin
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, mcand};
        nrem    = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        nquo    = {lo[XLEN-2:0], ~diff[XLEN]};
        div_res = f3[1] ? (neg_r ? -nrem : nrem) : (dz ? '1 : (neg_q ? -nquo : nquo));
    end
`endif

    always_comb begin
        state_nxt = state;
        valid_out = 1'b0;
        stall_out = 1'b0;
        alu_out   = base_res;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stall_out = 1'b1;
                    state_nxt = funct3[2] ? DIV : MUL;
                end else begin
                    valid_out = valid_in && !flush;
                    if (m_op && !m_iter) alu_out = '0;
                end
            end
            MUL, DIV: begin
                stall_out = 1'b1;
                if (last) state_nxt = DONE;
            end
            default: begin
                valid_out = !flush;
                alu_out   = m_result;
                state_nxt = IDLE;
            end
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign zero = (alu_out == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            m_result <= '0;
            f3       <= '0;
            neg_q    <= 1'b0;
`ifdef EX_STAGE_MD_DIV_EN
            neg_r    <= 1'b0;
            dz       <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                hi    <= '0;
                lo    <= abs_a;
                mcand <= abs_b;
                f3    <= funct3;
                neg_q <= a_neg ^ b_neg;
                cnt   <= '0;
`ifdef EX_STAGE_MD_DIV_EN
                neg_r <= a_neg;
                dz    <= (op_b == '0);
`endif
            end else if (state == MUL) begin
                hi  <= mul_hi;
                lo  <= mul_lo;
                cnt <= cnt + 1'b1;
                if (last) m_result <= mul_res;
            end
`ifdef EX_STAGE_MD_DIV_EN
            else if (state == DIV) begin
                hi  <= nrem;
                lo  <= nquo;
                cnt <= cnt + 1'b1;
                if (last) m_result <= div_res;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ex_stage_md.sv
// Directed self-checking bench for ex_stage_md (XLEN=32); divider vectors under EX_STAGE_MD_DIV_EN.
module tb_ex_stage_md;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, valid_in, alu_src, flush;
    logic [XLEN-1:0] rs1_data, rs2_data, imm, pc, wb_data, mem_data;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [1:0]      alu_op, fwd_a, fwd_b;
    logic [XLEN-1:0] alu_out, branch_target, store_data;
    logic            zero, valid_out, stall_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_stage_md #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .funct3(funct3), .funct7(funct7), .alu_op(alu_op), .alu_src(alu_src),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data), .mem_data(mem_data),
        .flush(flush), .alu_out(alu_out), .zero(zero), .branch_target(branch_target),
        .store_data(store_data), .valid_out(valid_out), .stall_out(stall_out)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in = 1'b0; alu_src = 1'b0; flush = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
        wb_data = '0; mem_data = '0;
        funct3 = '0; funct7 = '0; alu_op = '0; fwd_a = '0; fwd_b = '0;
    endtask

    task automatic alu_vec(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                           input logic [6:0] f7, input logic src, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] im,
                           input logic [XLEN-1:0] exp);
        alu_op = aop; funct3 = f3; funct7 = f7; alu_src = src;
        rs1_data = a; rs2_data = b; imm = im; fwd_a = 2'b00; fwd_b = 2'b00;
        valid_in = 1'b1;
        #1;
        check(tag, alu_out, exp);
        check({tag, "_valid"}, {31'd0, valid_out}, 1);
        step();
    endtask

    task automatic accept_mop(input string tag, input logic [2:0] f3,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = f3; alu_src = 1'b0;
        fwd_a = 2'b00; fwd_b = 2'b00; rs1_data = a; rs2_data = b; valid_in = 1'b1;
        #1;
        check({tag, "_accept"}, {30'd0, stall_out, valid_out}, 2'b10);
        step();
        valid_in = 1'b0; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h0000_1234; funct3 = ~f3;
    endtask

    task automatic run_mop(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        int bad;
        bad = 0;
        accept_mop(tag, f3, a, b);
        for (int c = 1; c <= 32; c++) begin
            if ({stall_out, valid_out} !== 2'b10) bad++;
            step();
        end
        check({tag, "_busy"}, bad, 0);
        check({tag, "_done_flags"}, {30'd0, stall_out, valid_out}, 2'b01);
        check({tag, "_result"}, alu_out, exp);
        step();
        check({tag, "_single"}, {31'd0, valid_out}, 0);
        clear_inputs();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        clear_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, valid_out}, 0);
        check("rst_stall", {31'd0, stall_out}, 0);
        check("rst_alu", alu_out, 0);
        check("rst_zero", {31'd0, zero}, 1);

        // Forwarded ADD and SUB / branch target
        alu_op = 2'b00; fwd_a = 2'b10; mem_data = 5; rs2_data = 7; valid_in = 1'b1;
        #1;
        check("add_fwd", alu_out, 12);
        check("add_zero", {31'd0, zero}, 0);
        check("add_valid", {31'd0, valid_out}, 1);
        check("add_stall", {31'd0, stall_out}, 0);
        step();
        alu_op = 2'b01; fwd_a = 2'b00; rs1_data = 9; rs2_data = 9; pc = 32'h100; imm = 32'h20;
        #1;
        check("sub_eq", alu_out, 0);
        check("sub_zero", {31'd0, zero}, 1);
        check("btarget", branch_target, 32'h120);
        pc = 32'hFFFF_FFF0; imm = 32'h20;
        #1;
        check("btarget_wrap", branch_target, 32'h10);
        step();

        alu_vec("r_sub",  2'b10, 3'b000, 7'b0100000, 1'b0, 10, 3, 0, 7);
        alu_vec("r_sra",  2'b10, 3'b101, 7'b0100000, 1'b0, 32'hF000_0000, 4, 0, 32'hFF00_0000);
        alu_vec("srai",   2'b11, 3'b101, 7'b0100000, 1'b1, 32'h8000_0000, 0, 32'h404, 32'hF800_0000);
        alu_vec("srli",   2'b11, 3'b101, 7'b0000000, 1'b1, 32'h8000_0000, 0, 32'h4, 32'h0800_0000);
        alu_vec("addi_f7", 2'b11, 3'b000, 7'b0100000, 1'b1, 32'h1000, 0, 32'h400, 32'h1400);
        alu_vec("slt",    2'b10, 3'b010, 7'b0000000, 1'b0, 32'hFFFF_FFFF, 1, 0, 1);
        alu_vec("sltu",   2'b10, 3'b011, 7'b0000000, 1'b0, 32'hFFFF_FFFF, 1, 0, 0);
        alu_vec("sll",    2'b10, 3'b001, 7'b0000000, 1'b0, 1, 32'h25, 0, 32'h20);
        alu_vec("xor",    2'b10, 3'b100, 7'b0000000, 1'b0, 32'hF0F0, 32'hFF00, 0, 32'h0FF0);
        alu_vec("or",     2'b10, 3'b110, 7'b0000000, 1'b0, 32'hF0F0, 32'hFF00, 0, 32'hFFF0);
        alu_vec("and",    2'b10, 3'b111, 7'b0000000, 1'b0, 32'hF0F0, 32'hFF00, 0, 32'hF000);

        // Operand-B forwarding and store_data tap before the imm mux
        clear_inputs();
        valid_in = 1'b1; rs1_data = 5; rs2_data = 9; fwd_b = 2'b11;
        #1;
        check("fwdb_zero", alu_out, 5);
        check("fwdb_zero_sd", store_data, 0);
        fwd_b = 2'b01; wb_data = 32'h55; alu_src = 1'b1; imm = 3; rs1_data = 0;
        #1;
        check("fwdb_wb_alu", alu_out, 3);
        check("fwdb_wb_sd", store_data, 32'h55);
        flush = 1'b1;
        #1;
        check("flush_base_valid", {31'd0, valid_out}, 0);
        step();
        clear_inputs();

        // Flushed M-op is never accepted
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000; valid_in = 1'b1; flush = 1'b1;
        #1;
        check("flush_mop_now", {30'd0, stall_out, valid_out}, 0);
        step();
        clear_inputs();
        #1;
        check("flush_mop_next", {31'd0, stall_out}, 0);

        run_mop("mul",    3'b000, 6, 7, 42);
        run_mop("mul_neg", 3'b000, 32'hFFFF_FFFD, 5, 32'hFFFF_FFF1);
        run_mop("mulh",   3'b001, 32'h8000_0000, 2, 32'hFFFF_FFFF);
        run_mop("mulhsu", 3'b010, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);
        run_mop("mulhu",  3'b011, 32'h8000_0000, 2, 1);

`ifdef EX_STAGE_MD_DIV_EN
        run_mop("div_by0",  3'b100, 7, 0, 32'hFFFF_FFFF);
        run_mop("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_mop("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_mop("div_neg",  3'b100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
        run_mop("rem_neg",  3'b110, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
        run_mop("divu",     3'b101, 20, 4, 5);
        run_mop("remu",     3'b111, 20, 6, 2);
        run_mop("rem_by0",  3'b110, 7, 0, 7);
        accept_mop("flushop", 3'b101, 100, 3);
`else
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b100; rs1_data = 20; rs2_data = 4;
        valid_in = 1'b1;
        #1;
        check("nodiv_alu", alu_out, 0);
        check("nodiv_flags", {30'd0, stall_out, valid_out}, 2'b01);
        step();
        clear_inputs();
        #1;
        check("nodiv_next_stall", {31'd0, stall_out}, 0);
        accept_mop("flushop", 3'b011, 100, 3);
`endif
        // Cycle 1 now; advance to cycle 10 and kill the operation
        for (int c = 2; c <= 10; c++) step();
        flush = 1'b1;
        #1;
        check("flush_c10_valid", {31'd0, valid_out}, 0);
        step();
        flush = 1'b0;
        #1;
        check("flush_c11_stall", {31'd0, stall_out}, 0);
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (valid_out !== 1'b0 || stall_out !== 1'b0) bad++;
            step();
        end
        check("flush_no_valid", bad, 0);
        clear_inputs();

        // Reset in cycle 5 of a multiply
        accept_mop("rstop", 3'b000, 6, 7);
        for (int c = 2; c <= 5; c++) step();
        reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        #1;
        check("rst_mid_stall", {31'd0, stall_out}, 0);
        check("rst_mid_valid", {31'd0, valid_out}, 0);
        check("rst_mid_alu", alu_out, 0);
        check("rst_mid_zero", {31'd0, zero}, 1);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid_out !== 1'b0 || stall_out !== 1'b0) bad++;
            step();
        end
        check("rst_mid_quiet", bad, 0);

        run_mop("mul_after_rst", 3'b000, 6, 7, 42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
